// File: rtl/l2_tcdm_fill_check_master_if.sv
// TCDM master/slave bundle: request channel plus in-order response channel.
// Shared by the fill/check initiator and the L2 bank responders.
interface l2_tcdm_fill_check_master_if;
  logic        req;
  logic [31:0] add;
  logic        wen;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        r_valid;
  logic [31:0] r_rdata;
  logic        r_opc;

  modport master (
    output req, add, wen, be, wdata,
    input  gnt, r_valid, r_rdata, r_opc
  );

  modport slave (
    input  req, add, wen, be, wdata,
    output gnt, r_valid, r_rdata, r_opc
  );
endinterface

// File: rtl/l2_tcdm_fill_check_master.sv
// L2 fill / readback-check initiator on a TCDM master port.
// Word k carries pattern+k at base+4k; responses are compared in order.
module l2_tcdm_fill_check_master #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned NUM_W           = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [1:0]       mode_i,
  input  logic [31:0]      base_addr_i,
  input  logic [NUM_W-1:0] num_words_i,
  input  logic [31:0]      pattern_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             error_o,
  output logic [NUM_W-1:0] err_count_o,
  output logic [31:0]      first_err_addr_o,
  l2_tcdm_fill_check_master_if.master tcdm
);

  localparam int unsigned PW =
    (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [2:0] {
    IDLE, FILL, CHECK, DRAIN, FINISH
  } state_e;

  typedef struct packed {
    logic        rd;
    logic [31:0] exp;
    logic [31:0] addr;
  } ent_t;

  state_e           state_q, state_d;
  logic             chk_q, chk_d;
  logic [31:0]      base_q, base_d;
  logic [31:0]      pat_q, pat_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic [NUM_W-1:0] left_q, left_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [NUM_W-1:0] err_q, err_d;
  logic [31:0]      ferr_q, ferr_d;
  ent_t             fifo_q [MAX_OUTSTANDING];

  logic issue, xfer, pop, mism;
  ent_t head, push_ent;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  // A response in this cycle frees its slot only from the next cycle on.
  assign issue = (state_q == FILL || state_q == CHECK) &&
                 (left_q != '0) &&
                 (cnt_q < CW'(MAX_OUTSTANDING));
  assign xfer  = issue & tcdm.gnt;
  assign pop   = tcdm.r_valid && (cnt_q != '0);
  assign head  = fifo_q[rptr_q];

  assign push_ent.rd   = (state_q == CHECK);
  assign push_ent.exp  = data_q;
  assign push_ent.addr = addr_q;

  assign mism = pop && (head.rd ?
    ((tcdm.r_rdata != head.exp) || tcdm.r_opc) : tcdm.r_opc);

  always_comb begin
    cnt_d  = cnt_q + CW'(xfer) - CW'(pop);
    wptr_d = xfer ? inc(wptr_q) : wptr_q;
    rptr_d = pop  ? inc(rptr_q) : rptr_q;
  end

  always_comb begin
    err_d  = err_q;
    ferr_d = ferr_q;
    if (state_q == IDLE && start_i) begin
      err_d  = '0;
      ferr_d = '0;
    end else if (mism) begin
      if (err_q != '1) err_d = err_q + NUM_W'(1);
      if (err_q == '0) ferr_d = head.addr;
    end
  end

  always_comb begin
    state_d = state_q;
    chk_d   = chk_q;
    base_d  = base_q;
    pat_d   = pat_q;
    num_d   = num_q;
    addr_d  = addr_q;
    data_d  = data_q;
    left_d  = left_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          chk_d  = mode_i[1];
          base_d = {base_addr_i[31:2], 2'b00};
          pat_d  = pattern_i;
          num_d  = num_words_i;
          addr_d = {base_addr_i[31:2], 2'b00};
          data_d = pattern_i;
          left_d = num_words_i;
          // Empty jobs pass through DRAIN so done keeps a fixed latency.
          if (mode_i == 2'b00 || num_words_i == '0) state_d = DRAIN;
          else if (mode_i[0])                       state_d = FILL;
          else                                      state_d = CHECK;
        end
      end
      FILL, CHECK: begin
        if (xfer) begin
          addr_d = addr_q + 32'd4;
          data_d = data_q + 32'd1;
          left_d = left_q - NUM_W'(1);
          if (left_q == NUM_W'(1)) begin
            if (state_q == FILL && chk_q) begin
              state_d = CHECK;
              addr_d  = base_q;
              data_d  = pat_q;
              left_d  = num_q;
            end else begin
              state_d = DRAIN;
            end
          end
        end
      end
      DRAIN:   if (cnt_d == '0) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tcdm.req         = issue;
    tcdm.add         = addr_q;
    tcdm.wen         = (state_q != FILL);
    tcdm.be          = 4'hF;
    tcdm.wdata       = data_q;
    busy_o           = (state_q == FILL) || (state_q == CHECK) ||
                       (state_q == DRAIN);
    done_o           = (state_q == FINISH);
    error_o          = (err_q != '0);
    err_count_o      = err_q;
    first_err_addr_o = ferr_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      chk_q   <= 1'b0;
      base_q  <= '0;
      pat_q   <= '0;
      num_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      left_q  <= '0;
      cnt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      err_q   <= '0;
      ferr_q  <= '0;
    end else begin
      state_q <= state_d;
      chk_q   <= chk_d;
      base_q  <= base_d;
      pat_q   <= pat_d;
      num_q   <= num_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      left_q  <= left_d;
      cnt_q   <= cnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (xfer) fifo_q[wptr_q] <= push_ent;
  end

endmodule

// File: tb/tb_l2_tcdm_fill_check_master.sv
// Directed bench: in-order TCDM responder model with latency, stalls
// and read corruption around the fill/check initiator.
module tb_l2_tcdm_fill_check_master;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  mode_i = '0;
  logic [31:0] base_addr_i = '0;
  logic [15:0] num_words_i = '0;
  logic [31:0] pattern_i = '0;
  logic        busy_o, done_o, error_o;
  logic [15:0] err_count_o;
  logic [31:0] first_err_addr_o;

  l2_tcdm_fill_check_master_if bus();

  l2_tcdm_fill_check_master #(
    .MAX_OUTSTANDING(2),
    .NUM_W(16)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .start_i(start_i),
    .mode_i(mode_i),
    .base_addr_i(base_addr_i),
    .num_words_i(num_words_i),
    .pattern_i(pattern_i),
    .busy_o(busy_o),
    .done_o(done_o),
    .error_o(error_o),
    .err_count_o(err_count_o),
    .first_err_addr_o(first_err_addr_o),
    .tcdm(bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          rel;
    logic        wen;
    logic [31:0] add;
    logic [31:0] wdata;
  } xf_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  int          cyc = 0;
  int          c0 = 0;
  int          lat = 1;
  bit          rnd_gnt = 0;
  bit          chk_stab = 0;
  bit          chk_out = 0;
  int          max_infl = 0;
  logic [31:0] corrupt = 32'hFFFF_FFFF;
  logic [31:0] mem [logic [31:0]];
  xf_t         lg [$];
  rsp_t        q [$];
  bit          held = 0;
  logic [31:0] h_add, h_wdata;
  logic        h_wen;

  always @(posedge clk) cyc++;

  initial begin
    bus.gnt     = 1'b0;
    bus.r_valid = 1'b0;
    bus.r_rdata = '0;
    bus.r_opc   = 1'b0;
  end

  always @(negedge clk) begin
    int   infl;
    rsp_t r;
    xf_t  x;
    logic [31:0] rd;
    infl = q.size();
    bus.r_valid = 1'b0;
    bus.r_rdata = '0;
    if (q.size() > 0 && q[0].due <= cyc) begin
      r = q.pop_front();
      bus.r_valid = 1'b1;
      bus.r_rdata = r.data;
    end
    bus.gnt = rnd_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
    if (chk_stab && held) begin
      check("stall_req", bus.req, 1);
      check("stall_add", bus.add, h_add);
      check("stall_wen", bus.wen, h_wen);
      check("stall_wdata", bus.wdata, h_wdata);
    end
    if (chk_out) begin
      if (infl > max_infl) max_infl = infl;
      if (infl >= 2) check("req_when_full", bus.req, 0);
    end
    if (bus.req && bus.gnt) begin
      x.rel = cyc - c0;
      x.wen = bus.wen;
      x.add = bus.add;
      x.wdata = bus.wdata;
      lg.push_back(x);
      rd = '0;
      if (!bus.wen) mem[bus.add] = bus.wdata;
      else if (bus.add == corrupt) rd = '0;
      else if (mem.exists(bus.add)) rd = mem[bus.add];
      r.due = cyc + lat;
      r.data = rd;
      q.push_back(r);
    end
    held    = bus.req && !bus.gnt;
    h_add   = bus.add;
    h_wen   = bus.wen;
    h_wdata = bus.wdata;
  end

  task automatic run(input logic [1:0] m, input logic [31:0] b,
                     input logic [15:0] n, input logic [31:0] p,
                     input int poke, input int budget,
                     output int drel);
    lg.delete();
    @(negedge clk);
    mode_i = m;
    base_addr_i = b;
    num_words_i = n;
    pattern_i = p;
    start_i = 1'b1;
    c0 = cyc;
    drel = -1;
    @(negedge clk);
    start_i = 1'b0;
    mode_i = 2'b11;
    base_addr_i = '1;
    num_words_i = 16'd7;
    pattern_i = '0;
    check("busy_rel1", busy_o, 1);
    for (int i = 1; i <= budget && drel < 0; i++) begin
      if (done_o) drel = cyc - c0;
      else begin
        start_i = (i == poke);
        @(negedge clk);
      end
    end
    start_i = 1'b0;
    if (drel < 0) check("done_timeout", 0, 1);
    else check("busy_at_done", busy_o, 0);
  endtask

  initial begin
    int d;
    int dn;
    #12;
    check("rst_req", bus.req, 0);
    check("rst_wen", bus.wen, 1);
    check("rst_be", bus.be, 4'hF);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_count_o, 0);
    check("rst_ferr", first_err_addr_o, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk);

    // plain fill, 1-cycle responder
    run(2'b01, 32'h1C01_0002, 16'd4, 32'hA5A5_0000, 0, 50, d);
    check("t1_done", d, 6);
    check("t1_n", lg.size(), 4);
    for (int k = 0; k < 4 && k < lg.size(); k++) begin
      check("t1_add", lg[k].add, 32'h1C01_0000 + 32'(4 * k));
      check("t1_wdata", lg[k].wdata, 32'hA5A5_0000 + 32'(k));
      check("t1_wen", lg[k].wen, 0);
      check("t1_rel", lg[k].rel, k + 1);
    end
    check("t1_errcnt", err_count_o, 0);

    // fill then check, word 2 corrupted
    corrupt = 32'h1C00_0008;
    run(2'b11, 32'h1C00_0000, 16'd8, 32'h100, 0, 100, d);
    check("t2_done", d, 18);
    check("t2_n", lg.size(), 16);
    if (lg.size() == 16) begin
      check("t2_rd0_wen", lg[8].wen, 1);
      check("t2_rd0_add", lg[8].add, 32'h1C00_0000);
      check("t2_rd0_rel", lg[8].rel, 9);
      check("t2_last_rel", lg[15].rel, 16);
      check("t2_wr7", lg[7].wdata, 32'h107);
    end
    check("t2_errcnt", err_count_o, 1);
    check("t2_ferr", first_err_addr_o, 32'h1C00_0008);
    check("t2_error", error_o, 1);
    repeat (3) @(negedge clk);
    check("t2_hold_err", err_count_o, 1);
    check("t2_hold_ferr", first_err_addr_o, 32'h1C00_0008);
    corrupt = 32'hFFFF_FFFF;

    // random grant stalls
    rnd_gnt = 1;
    chk_stab = 1;
    run(2'b11, 32'h1C00_2000, 16'd16, 32'hDEAD_0000, 0, 2000, d);
    rnd_gnt = 0;
    chk_stab = 0;
    check("t3_n", lg.size(), 32);
    check("t3_errcnt", err_count_o, 0);
    check("t3_ferr", first_err_addr_o, 0);
    check("t3_mem15", mem[32'h1C00_203C], 32'hDEAD_000F);

    // 3-cycle responder, outstanding limit
    lat = 3;
    chk_out = 1;
    max_infl = 0;
    repeat (4) @(negedge clk);
    run(2'b11, 32'h1C00_3000, 16'd6, 32'h55, 0, 300, d);
    chk_out = 0;
    check("t4_n", lg.size(), 12);
    check("t4_maxinfl", max_infl, 2);
    check("t4_errcnt", err_count_o, 0);
    lat = 1;
    repeat (4) @(negedge clk);

    // empty jobs and start while busy
    run(2'b00, 32'h1C00_4000, 16'd5, 32'h1, 0, 20, d);
    check("t5_m0_done", d, 2);
    check("t5_m0_n", lg.size(), 0);
    run(2'b01, 32'h1C00_4000, 16'd0, 32'h1, 0, 20, d);
    check("t5_n0_done", d, 2);
    check("t5_n0_n", lg.size(), 0);
    run(2'b01, 32'h1C00_5000, 16'd3, 32'h50, 2, 40, d);
    check("t5_busy_done", d, 5);
    check("t5_busy_n", lg.size(), 3);
    dn = 0;
    repeat (6) begin
      @(negedge clk);
      if (done_o || busy_o) dn++;
    end
    check("t5_no_rerun", dn, 0);

    // reset in the middle of the check phase
    lat = 3;
    corrupt = 32'h1C00_6004;
    @(negedge clk);
    mode_i = 2'b11;
    base_addr_i = 32'h1C00_6000;
    num_words_i = 16'd16;
    pattern_i = 32'h7;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int i = 0; i < 400 && err_count_o == 0; i++) @(negedge clk);
    check("t6_pre_err", err_count_o, 1);
    check("t6_pre_busy", busy_o, 1);
    rst_ni = 1'b0;
    #1;
    check("t6_rst_req", bus.req, 0);
    check("t6_rst_wen", bus.wen, 1);
    check("t6_rst_busy", busy_o, 0);
    check("t6_rst_err", err_count_o, 0);
    check("t6_rst_error", error_o, 0);
    check("t6_rst_ferr", first_err_addr_o, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    repeat (6) @(negedge clk);
    check("t6_stale_err", err_count_o, 0);
    check("t6_stale_busy", busy_o, 0);
    corrupt = 32'hFFFF_FFFF;
    run(2'b11, 32'h1C00_7000, 16'd4, 32'h900, 0, 200, d);
    check("t6_n", lg.size(), 8);
    check("t6_errcnt", err_count_o, 0);
    check("t6_error", error_o, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
